parking_gate_decoder: RTL and testbench

Converts the two raw photo-beam sensors at the parking-lot gate into single-cycle `inc` and `dec` pulses for the occupancy counter. Entry is defined as beam A (outer), then A+B, then B (inner), then clear; exit is the reverse sequence. Inputs are synchronised and debounced. Aborted, illegal or stalled sequences never produce a count pulse.

---
 rtl/parking_gate_decoder_pkg.sv | 23 ++
 rtl/parking_gate_decoder_sensor_debounce.sv | 44 ++++
 rtl/parking_gate_decoder.sv | 147 ++++++++++++++
 tb/tb_parking_gate_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/parking_gate_decoder_pkg.sv
// Shared types and defaults for the parking-gate beam decoder.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENT_A,
      ENT_AB,
      ENT_B,
      EXT_B,
      EXT_AB,
      EXT_A,
      WAIT_CLEAR
   } gate_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 8;
   localparam int TIMEOUT_CYCLES_DEF  = 1024;

   // True for the states that belong to an in-progress entry or exit.
   function automatic logic is_seq_state(input gate_state_t s);
      return (s != IDLE) && (s != WAIT_CLEAR);
   endfunction

endpackage

// File: rtl/parking_gate_decoder_sensor_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer for one beam.
module sensor_debounce
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic deb
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_deb;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         // Any return to the accepted level restarts the stability count.
         if (r_sync2 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign deb = r_deb;

endmodule

// File: rtl/parking_gate_decoder.sv
// Turns the outer/inner gate beams into registered inc/dec/err pulses for the
// occupancy counter, rejecting aborted, illegal and stalled sequences.
module parking_gate_decoder
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sensor_a,
   input  logic sensor_b,
   output logic inc,
   output logic dec,
   output logic err,
   output logic busy
);

   localparam int DW_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(TIMEOUT_CYCLES - 1);

   logic            w_deb_a;
   logic            w_deb_b;
   logic [1:0]      w_ab;
   gate_state_t     r_state;
   gate_state_t     w_next;
   logic [DW_W-1:0] r_dwell;
   logic            r_inc, r_dec, r_err;
   logic            w_inc, w_dec, w_err;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sensor_a),
      .deb   (w_deb_a)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sensor_b),
      .deb   (w_deb_b)
   );

   assign w_ab = {w_deb_a, w_deb_b};

   always_comb begin
      w_next = r_state;
      w_inc  = 1'b0;
      w_dec  = 1'b0;
      w_err  = 1'b0;
      unique case (r_state)
         IDLE: begin
            case (w_ab)
               2'b10:   w_next = ENT_A;
               2'b01:   w_next = EXT_B;
               2'b11:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = IDLE;
            endcase
         end
         ENT_A: begin
            case (w_ab)
               2'b11:   w_next = ENT_AB;
               2'b00:   w_next = IDLE;
               2'b01:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = ENT_A;
            endcase
         end
         ENT_AB: begin
            case (w_ab)
               2'b01:   w_next = ENT_B;
               2'b10:   w_next = ENT_A;
               2'b00:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = ENT_AB;
            endcase
         end
         ENT_B: begin
            case (w_ab)
               2'b00:   begin w_next = IDLE; w_inc = 1'b1; end
               2'b11:   w_next = ENT_AB;
               2'b10:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = ENT_B;
            endcase
         end
         EXT_B: begin
            case (w_ab)
               2'b11:   w_next = EXT_AB;
               2'b00:   w_next = IDLE;
               2'b10:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = EXT_B;
            endcase
         end
         EXT_AB: begin
            case (w_ab)
               2'b10:   w_next = EXT_A;
               2'b01:   w_next = EXT_B;
               2'b00:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = EXT_AB;
            endcase
         end
         EXT_A: begin
            case (w_ab)
               2'b00:   begin w_next = IDLE; w_dec = 1'b1; end
               2'b11:   w_next = EXT_AB;
               2'b01:   begin w_next = WAIT_CLEAR; w_err = 1'b1; end
               default: w_next = EXT_A;
            endcase
         end
         WAIT_CLEAR: begin
            if (w_ab == 2'b00) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase

      // A stalled sequence times out only when no beam change is moving it on.
      if (is_seq_state(r_state) && (w_next == r_state) && (r_dwell == DWELL_MAX)) begin
         w_next = WAIT_CLEAR;
         w_err  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_dwell <= '0;
         r_inc   <= 1'b0;
         r_dec   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_inc   <= w_inc;
         r_dec   <= w_dec;
         r_err   <= w_err;
         if ((w_next != r_state) || !is_seq_state(r_state)) begin
            r_dwell <= '0;
         end else begin
            r_dwell <= r_dwell + DW_W'(1);
         end
      end
   end

   assign inc  = r_inc;
   assign dec  = r_dec;
   assign err  = r_err;
   assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_parking_gate_decoder.sv
// Scoreboard bench for parking_gate_decoder with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_parking_gate_decoder;

   localparam int DEB = 4;
   localparam int TMO = 64;
   localparam int LAT = 3 + DEB;
   localparam int K_NONE = 0;
   localparam int K_INC  = 1;
   localparam int K_DEC  = 2;
   localparam int K_ERR  = 3;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sensor_a = 1'b0;
   logic sensor_b = 1'b0;
   logic inc, dec, err, busy;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   bit   busy_seen = 1'b0;
   logic prev_busy = 1'b0;

   parking_gate_decoder #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sensor_a (sensor_a),
      .sensor_b (sensor_b),
      .inc      (inc),
      .dec      (dec),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expected event per observed pulse cycle.
   always @(negedge clk) begin
      int   kind;
      exp_t e;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (inc || dec || err) begin
         chk("pulse_exclusive", int'(inc) + int'(dec) + int'(err), 1);
         kind = inc ? K_INC : (dec ? K_DEC : K_ERR);
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", kind, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_cycle", cyc, e.cyc);
         end
         if (inc || dec) begin
            chk("busy_low_with_pulse", int'(busy), 0);
            chk("busy_high_before_pulse", int'(prev_busy), 1);
         end
      end
      prev_busy = busy;
   end

   // Apply a debounced-pair step at a falling edge and hold it.
   task automatic step(input logic a, input logic b, input int kind = K_NONE,
                       input int hold = 10, input int lat = LAT);
      exp_t e;
      sensor_a = a;
      sensor_b = b;
      if (kind != K_NONE) begin
         e.kind = kind;
         e.cyc  = cyc + lat;
         q.push_back(e);
      end
      repeat (hold) @(negedge clk);
   endtask

   task automatic drained(input string name);
      chk(name, q.size(), 0);
   endtask

   task automatic entry_seq();
      step(1, 0);
      step(1, 1);
      step(0, 1);
      step(0, 0, K_INC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_inc", int'(inc), 0);
      chk("reset_dec", int'(dec), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      entry_seq();
      drained("entry_drained");

      step(0, 1);
      step(1, 1);
      step(1, 0);
      step(0, 0, K_DEC);
      drained("exit_drained");

      step(1, 0);
      step(0, 0);
      drained("backout_drained");
      chk("backout_idle", int'(busy), 0);

      step(1, 0);
      step(1, 1);
      step(1, 0);
      step(1, 1);
      step(0, 1);
      step(0, 0, K_INC);
      drained("reversal_drained");

      busy_seen = 1'b0;
      sensor_a = 1'b1;
      repeat (3) @(negedge clk);
      sensor_a = 1'b0;
      repeat (20) @(negedge clk);
      chk("glitch3_busy_seen", int'(busy_seen), 0);

      busy_seen = 1'b0;
      sensor_a = 1'b1;
      repeat (4) @(negedge clk);
      sensor_a = 1'b0;
      repeat (20) @(negedge clk);
      chk("glitch4_busy_seen", int'(busy_seen), 1);
      chk("glitch4_idle", int'(busy), 0);
      drained("glitch_drained");

      step(1, 0);
      step(0, 1, K_ERR, 30);
      chk("wait_clear_hold", int'(busy), 1);
      step(0, 0);
      chk("illegal_idle", int'(busy), 0);
      drained("illegal_drained");

      step(1, 0);
      step(1, 1, K_ERR, 100, LAT + TMO);
      step(0, 1);
      step(0, 0);
      chk("timeout_idle", int'(busy), 0);
      drained("timeout_drained");

      step(1, 0);
      step(1, 1);
      chk("pre_reset_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_inc", int'(inc), 0);
      chk("async_rst_dec", int'(dec), 0);
      chk("async_rst_err", int'(err), 0);
      chk("async_rst_busy", int'(busy), 0);
      sensor_a = 1'b0;
      sensor_b = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("post_reset_idle", int'(busy), 0);
      drained("post_reset_drained");
      entry_seq();
      drained("post_reset_entry_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
